zip_alu_pipe: RTL and testbench

- Parametrised next-generation integer ALU for the ZipCPU execute stage.
- Generalises the fixed 32-bit ALU in three ways: data width DW, a configurable pipelined multiplier latency, and a full 2*DW-bit multiply with signed/unsigned high-half results.
- Every issued op produces exactly one o_valid pulse with result and flags. The block asserts o_busy while a multi-cycle multiply is in flight.

---
 rtl/zip_alu_pipe.sv | 147 ++++++++++++++
 tb/tb_zip_alu_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zip_alu_pipe.sv
// Parametrised ZipCPU execute-stage ALU with a full-width multiplier.
// Single-cycle ops register their result directly; a multi-cycle multiply holds o_busy until it retires.
module zip_alu_pipe #(
  parameter int DW        = 32,
  parameter int MPY_LAT   = 3,
  parameter int SAT_SHIFT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_c,
  output logic [3:0]    o_f,
  output logic          o_valid,
  output logic          o_busy
);

  localparam int            LW     = $clog2(DW);
  localparam logic [DW-1:0] DW_N   = {{(DW-LW-1){1'b0}}, (LW+1)'(DW)};
  localparam logic [DW-1:0] ONE    = DW'(1);
  localparam logic [2:0]    LAT_M1 = 3'(MPY_LAT - 1);

  logic [DW-1:0]   c_q, mpy_q;
  logic [3:0]      f_q;
  logic            valid_q, busy_q;
  logic [2:0]      cnt_q;

  logic [DW-1:0]   c_d, n_sh, mpy_sel, mpy_hi_s;
  logic [3:0]      f_d;
  logic            cf, vf, is_mpy;
  logic [DW:0]     sum, dif;
  logic [2*DW-1:0] prod_u;

  // One unsigned multiplier; the signed high half is corrected from it.
  always_comb begin
    prod_u   = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
    mpy_hi_s = prod_u[2*DW-1:DW] - (i_a[DW-1] ? i_b : '0) - (i_b[DW-1] ? i_a : '0);
    mpy_sel  = '0;
    if (MPY_LAT != 0) begin
      case (i_op)
        4'hA:    mpy_sel = prod_u[2*DW-1:DW];
        4'hB:    mpy_sel = mpy_hi_s;
        default: mpy_sel = prod_u[DW-1:0];
      endcase
    end
  end

  assign is_mpy = (i_op == 4'hA) || (i_op == 4'hB) || (i_op == 4'hC);

  always_comb begin
    sum  = {1'b0, i_a} + {1'b0, i_b};
    dif  = {1'b0, i_a} - {1'b0, i_b};
    n_sh = (SAT_SHIFT != 0) ? i_b : {{(DW-LW){1'b0}}, i_b[LW-1:0]};
    c_d  = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    case (i_op)
      4'h0: begin
        c_d = dif[DW-1:0];
        cf  = dif[DW];
        vf  = (i_a[DW-1] != i_b[DW-1]) && (dif[DW-1] != i_a[DW-1]);
      end
      4'h1: c_d = i_a & i_b;
      4'h2: begin
        c_d = sum[DW-1:0];
        cf  = sum[DW];
        vf  = (i_a[DW-1] == i_b[DW-1]) && (sum[DW-1] != i_a[DW-1]);
      end
      4'h3: c_d = i_a | i_b;
      4'h4: c_d = i_a ^ i_b;
      4'h5: begin
        c_d = (n_sh == '0) ? i_a : '0;
        if (n_sh != '0 && n_sh <= DW_N) begin
          c_d = i_a >> n_sh;
          cf  = |(i_a & (ONE << (n_sh - ONE)));
        end
        vf = c_d[DW-1] != i_a[DW-1];
      end
      4'h6: begin
        c_d = (n_sh == '0) ? i_a : '0;
        if (n_sh != '0 && n_sh <= DW_N) begin
          c_d = i_a << n_sh;
          cf  = |(i_a & (ONE << (DW_N - n_sh)));
        end
        vf = c_d[DW-1] != i_a[DW-1];
      end
      4'h7: begin
        if (n_sh == '0) begin
          c_d = i_a;
        end else if (n_sh < DW_N) begin
          c_d = $signed(i_a) >>> n_sh;
          cf  = |(i_a & (ONE << (n_sh - ONE)));
        end else begin
          c_d = {DW{i_a[DW-1]}};
          cf  = i_a[DW-1];
        end
      end
      4'h8: for (int i = 0; i < DW; i++) c_d[i] = i_b[DW-1-i];
      4'h9: c_d = {i_a[DW-1:DW/2], i_b[DW/2-1:0]};
      4'hA, 4'hB, 4'hC: c_d = mpy_sel;
      default: c_d = i_b;
    endcase
    f_d = {vf, c_d[DW-1], cf, ~|c_d};
  end

  // The multiply result is captured at accept and released when the latency counter expires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c_q     <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mpy_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (busy_q) begin
        if (cnt_q == 3'd1) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          c_q     <= mpy_q;
          f_q     <= {1'b0, mpy_q[DW-1], 1'b0, ~|mpy_q};
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end else if (i_ce) begin
        if (is_mpy && MPY_LAT >= 2) begin
          busy_q <= 1'b1;
          cnt_q  <= LAT_M1;
          mpy_q  <= mpy_sel;
        end else begin
          valid_q <= 1'b1;
          c_q     <= c_d;
          f_q     <= f_d;
        end
      end
    end
  end

  assign o_c     = c_q;
  assign o_f     = f_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_zip_alu_pipe.sv
// Scoreboard bench for zip_alu_pipe: a DW=32/MPY_LAT=3 instance and a DW=16/MPY_LAT=1 instance.
module tb_zip_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        ce32 = 1'b0;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, c32;
  logic [3:0]  f32;
  logic        v32, bz32;

  logic        ce16 = 1'b0;
  logic [3:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, c16;
  logic [3:0]  f16;
  logic        v16, bz16;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] c;
    logic [3:0]  f;
  } exp_t;

  exp_t q32[$], q16[$];
  exp_t e32, e16;
  int n_chk = 0, n_fail = 0;

  zip_alu_pipe #(.DW(32), .MPY_LAT(3), .SAT_SHIFT(1)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce32), .i_op(op32), .i_a(a32), .i_b(b32),
    .o_c(c32), .o_f(f32), .o_valid(v32), .o_busy(bz32));

  zip_alu_pipe #(.DW(16), .MPY_LAT(1), .SAT_SHIFT(1)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_ce(ce16), .i_op(op16), .i_a(a16), .i_b(b16),
    .o_c(c16), .o_f(f16), .o_valid(v16), .o_busy(bz16));

  // Scoreboard pop/compare whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && v32 === 1'b1) begin
      n_chk++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL dw32_unexpected_valid: got c=%h f=%b, required no result", c32, f32);
      end else begin
        e32 = q32.pop_front();
        if ({c32, f32} !== {e32.c, e32.f}) begin
          n_fail++;
          $display("FAIL dw32_op%h: got c=%h f=%b, required c=%h f=%b", e32.op, c32, f32, e32.c, e32.f);
        end
      end
    end
    if (!rst && v16 === 1'b1) begin
      n_chk++;
      if (q16.size() == 0) begin
        n_fail++;
        $display("FAIL dw16_unexpected_valid: got c=%h f=%b, required no result", c16, f16);
      end else begin
        e16 = q16.pop_front();
        if ({16'h0, c16, f16} !== {e16.c, e16.f}) begin
          n_fail++;
          $display("FAIL dw16_op%h: got c=%h f=%b, required c=%h f=%b", e16.op, c16, f16, e16.c[15:0], e16.f);
        end
      end
    end
  end

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic [3:0] ef);
    exp_t e;
    int k = 0;
    @(negedge clk);
    while (bz32 !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    if (bz32 !== 1'b0) begin
      n_chk++; n_fail++;
      $display("FAIL issue32_busy_timeout: got busy=%b, required 0", bz32);
    end
    e.op = op; e.c = ec; e.f = ef;
    q32.push_back(e);
    ce32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1 ce32 = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ec, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    e.op = op; e.c = {16'h0, ec}; e.f = ef;
    q16.push_back(e);
    ce16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1 ce16 = 1'b0;
  endtask

  task automatic drain;
    int k = 0;
    while ((q32.size() != 0 || q16.size() != 0) && k < 30) begin @(negedge clk); k++; end
    @(negedge clk);
    if (q32.size() != 0 || q16.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0", q32.size(), q16.size());
      q32.delete(); q16.delete();
    end
  endtask

  // Independent reference for the arithmetic/logic subset, returns {V,N,C,Z,c}.
  function automatic logic [35:0] model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    logic v, cy;
    v = 1'b0; cy = 1'b0;
    case (op)
      4'h0: begin c = a - b; cy = (a < b); v = (a[31] ^ b[31]) & (c[31] ^ a[31]); end
      4'h1: c = a & b;
      4'h2: begin c = a + b; cy = (c < a); v = ~(a[31] ^ b[31]) & (c[31] ^ a[31]); end
      4'h3: c = a | b;
      4'h4: c = a ^ b;
      default: c = b;
    endcase
    return {v, c[31], cy, (c == 32'h0), c};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk += 8;
    if (v32 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid32: got %b, required 0", v32); end
    if (bz32 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy32: got %b, required 0", bz32); end
    if (c32 !== 32'h0)  begin n_fail++; $display("FAIL reset_c32: got %h, required 0", c32); end
    if (f32 !== 4'h0)   begin n_fail++; $display("FAIL reset_f32: got %b, required 0", f32); end
    if (v16 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid16: got %b, required 0", v16); end
    if (bz16 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy16: got %b, required 0", bz16); end
    if (c16 !== 16'h0)  begin n_fail++; $display("FAIL reset_c16: got %h, required 0", c16); end
    if (f16 !== 4'h0)   begin n_fail++; $display("FAIL reset_f16: got %b, required 0", f16); end
    rst = 1'b0;
  endtask

  task automatic test_add_sub;
    issue32(4'h2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1100);
    @(negedge clk);
    n_chk++;
    if (v32 !== 1'b1) begin n_fail++; $display("FAIL add_pulse_high: got %b, required 1", v32); end
    @(negedge clk);
    n_chk += 2;
    if (v32 !== 1'b0) begin n_fail++; $display("FAIL add_pulse_low: got %b, required 0", v32); end
    if (c32 !== 32'h8000_0000) begin n_fail++; $display("FAIL add_hold: got %h, required 80000000", c32); end
    issue32(4'h0, 32'h5, 32'h5, 32'h0, 4'b0001);
    issue32(4'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 4'b0110);
    issue32(4'h2, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0011);
    issue32(4'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b1000);
    drain();
  endtask

  task automatic test_shifts;
    issue32(4'h5, 32'h8000_0001, 32'd1,  32'h4000_0000, 4'b1010);
    issue32(4'h5, 32'h8000_0001, 32'd32, 32'h0,         4'b1011);
    issue32(4'h5, 32'h8000_0001, 32'd33, 32'h0,         4'b1001);
    issue32(4'h5, 32'h8000_0001, 32'd0,  32'h8000_0001, 4'b0100);
    issue32(4'h7, 32'h8000_0001, 32'd40, 32'hFFFF_FFFF, 4'b0110);
    issue32(4'h7, 32'h8000_0001, 32'd4,  32'hF800_0000, 4'b0100);
    issue32(4'h7, 32'h8000_0001, 32'd1,  32'hC000_0000, 4'b0110);
    issue32(4'h6, 32'h8000_0001, 32'd32, 32'h0,         4'b1011);
    issue32(4'h6, 32'h8000_0001, 32'd1,  32'h0000_0002, 4'b1010);
    issue32(4'h6, 32'h8000_0001, 32'd40, 32'h0,         4'b1001);
    issue32(4'h8, 32'h0,         32'h1,  32'h8000_0000, 4'b0100);
    issue32(4'h9, 32'hABCD_1234, 32'h0000_5678, 32'hABCD_5678, 4'b0100);
    issue32(4'hD, 32'h1234_5678, 32'h0,  32'h0,         4'b0001);
    issue32(4'hF, 32'h0,         32'h0000_0042, 32'h0000_0042, 4'b0000);
    drain();
  endtask

  task automatic test_back_to_back;
    logic [3:0] ops [6];
    logic [35:0] m;
    logic [3:0] op;
    logic [31:0] a, b;
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'h4; ops[5] = 4'hE;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom();
      b  = (i % 4 == 0) ? a : $urandom();
      m  = model32(op, a, b);
      issue32(op, a, b, m[31:0], m[35:32]);
    end
    drain();
  endtask

  task automatic test_mpy;
    exp_t e;
    @(negedge clk);
    ce32 = 1'b1; op32 = 4'hB; a32 = 32'hFFFF_FFFF; b32 = 32'h2;
    e.op = 4'hB; e.c = 32'hFFFF_FFFF; e.f = 4'b0100; q32.push_back(e);
    @(negedge clk);
    n_chk += 2;
    if (bz32 !== 1'b1) begin n_fail++; $display("FAIL mpy_busy_t1: got %b, required 1", bz32); end
    if (v32 !== 1'b0)  begin n_fail++; $display("FAIL mpy_valid_t1: got %b, required 0", v32); end
    op32 = 4'h2; a32 = 32'h1; b32 = 32'h1;
    @(negedge clk);
    n_chk += 2;
    if (bz32 !== 1'b1) begin n_fail++; $display("FAIL mpy_busy_t2: got %b, required 1", bz32); end
    if (v32 !== 1'b0)  begin n_fail++; $display("FAIL mpy_valid_t2: got %b, required 0", v32); end
    op32 = 4'hA; a32 = 32'hFFFF_FFFF; b32 = 32'h2;
    e.op = 4'hA; e.c = 32'h0000_0001; e.f = 4'b0000; q32.push_back(e);
    @(negedge clk);
    n_chk += 2;
    if (bz32 !== 1'b0) begin n_fail++; $display("FAIL mpy_busy_t3: got %b, required 0", bz32); end
    if (v32 !== 1'b1)  begin n_fail++; $display("FAIL mpy_valid_t3: got %b, required 1", v32); end
    @(posedge clk); #1 ce32 = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bz32 !== 1'b1) begin n_fail++; $display("FAIL mpy_b2b_busy: got %b, required 1", bz32); end
    issue32(4'hC, 32'h3,         32'h5,         32'h0000_000F, 4'b0000);
    issue32(4'hC, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 4'b0100);
    issue32(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100);
    issue32(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         4'b0001);
    issue32(4'hB, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000);
    drain();
  endtask

  task automatic test_reset_mid_mpy;
    @(negedge clk);
    ce32 = 1'b1; op32 = 4'hC; a32 = 32'h3; b32 = 32'h5;
    @(posedge clk); #1 ce32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk += 2;
    if (bz32 !== 1'b0) begin n_fail++; $display("FAIL rstmpy_busy: got %b, required 0", bz32); end
    if (v32 !== 1'b0)  begin n_fail++; $display("FAIL rstmpy_valid: got %b, required 0", v32); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (v32 !== 1'b0) begin n_fail++; $display("FAIL rstmpy_late_valid%0d: got %b, required 0", i, v32); end
    end
    issue32(4'h2, 32'h1, 32'h1, 32'h2, 4'b0000);
    drain();
  endtask

  task automatic test_dw16;
    exp_t e;
    @(negedge clk);
    ce16 = 1'b1; op16 = 4'hC; a16 = 16'h0100; b16 = 16'h0100;
    e.op = 4'hC; e.c = 32'h0; e.f = 4'b0001; q16.push_back(e);
    @(posedge clk); #1 ce16 = 1'b0;
    @(negedge clk);
    n_chk += 2;
    if (v16 !== 1'b1)  begin n_fail++; $display("FAIL dw16_mpy_latency: got valid=%b, required 1", v16); end
    if (bz16 !== 1'b0) begin n_fail++; $display("FAIL dw16_mpy_busy: got %b, required 0", bz16); end
    issue16(4'h9, 16'hABCD, 16'h1234, 16'hAB34, 4'b0100);
    issue16(4'hB, 16'hFFFF, 16'h0002, 16'hFFFF, 4'b0100);
    issue16(4'hA, 16'hFFFF, 16'h0002, 16'h0001, 4'b0000);
    @(negedge clk);
    n_chk++;
    if (bz16 !== 1'b0) begin n_fail++; $display("FAIL dw16_b2b_busy: got %b, required 0", bz16); end
    issue16(4'h5, 16'h8001, 16'd16, 16'h0000, 4'b1011);
    issue16(4'h7, 16'h8001, 16'd20, 16'hFFFF, 4'b0110);
    issue16(4'h6, 16'h8001, 16'd17, 16'h0000, 4'b1001);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_shifts();
    test_back_to_back();
    test_mpy();
    test_reset_mid_mpy();
    test_dw16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
